// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI slave front end that decodes 16-bit frames into register
// read/write cycles and serialises read data back on miso.
module spi_reg_slave #(
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              spioe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              frame_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] sclk_q, ss_q, mosi_q;
    logic sclk_d, rise, ss_s, mosi_s;
    logic armed, rnw, rd_d, loaded, addr_end, last, abort;
    logic [3:0] bitcnt;
    logic [6:0] sr;
    logic [7:0] sh, byte_n;

    // No reset on the synchronisers: a reset while ss is high must not look like a fresh ss edge
    always_ff @(posedge clk) begin
        sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
        ss_q   <= {ss_q[SYNC_STAGES-2:0], ss};
        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
        sclk_d <= sclk_q[SYNC_STAGES-1];
    end

    assign ss_s     = ss_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign rise     = sclk_q[SYNC_STAGES-1] & ~sclk_d;
    assign byte_n   = {sr, mosi_s};
    assign addr_end = state == ADDR && rise && bitcnt == 4'd7;
    assign last     = state == DATA && rise && bitcnt == 4'd15;
    assign abort    = (state == ADDR || state == DATA) && !ss_s && !last;
    assign spioe    = state == DATA && rnw && loaded;
    assign miso     = spioe & sh[7];

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = (ss_s && armed) ? ADDR : IDLE;
            ADDR: state_n = !ss_s ? IDLE : addr_end ? DATA : ADDR;
            DATA: state_n = last ? (ss_s ? DONE : IDLE) : !ss_s ? IDLE : DATA;
            DONE: state_n = ss_s ? DONE : IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt    <= '0;
            sr        <= '0;
            sh        <= '0;
            rnw       <= 1'b0;
            rd_d      <= 1'b0;
            loaded    <= 1'b0;
            armed     <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            reg_wr    <= last && !rnw;
            reg_rd    <= addr_end && byte_n[7];
            rd_d      <= reg_rd;
            armed     <= armed | ~ss_s;
            frame_err <= frame_err | abort;
            if (state == IDLE)
                bitcnt <= '0;
            else if (rise && (state == ADDR || state == DATA)) begin
                bitcnt <= bitcnt + 4'd1;
                sr     <= byte_n[6:0];
            end
            if (addr_end) begin
                reg_addr <= byte_n[ADDR_W-1:0];
                rnw      <= byte_n[7];
            end
            if (last && !rnw)
                reg_wdata <= byte_n;
            // Bank answers one cycle after reg_rd, so load from the delayed strobe
            if (rd_d) begin
                sh     <= reg_rdata;
                loaded <= 1'b1;
            end else begin
                if (state != DATA)
                    loaded <= 1'b0;
                if (rise && state == DATA && loaded)
                    sh <= {sh[6:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: drives randomised SPI frames and checks register cycles and
// read-back data against a simple register-array model.
module tb_spi_reg_slave;
    logic clk = 1'b0;
    logic reset, sclk, ss, mosi;
    logic miso, spioe, reg_wr, reg_rd, frame_err;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata = 8'h00;

    logic [7:0] bank [128];
    logic [7:0] model [128];
    logic pre_en = 1'b0;
    logic [6:0] pre_a = '0;
    logic [7:0] pre_d = '0;

    int n_checks = 0, n_errors = 0;
    int wr_cnt = 0, rd_cnt = 0, oe_bad = 0, miso_bad = 0, oe_miss = 0, n_rise = 0;
    logic cur_rd = 1'b0, err_exp = 1'b0;
    logic [6:0] wr_addr = '0, rd_addr = '0;
    logic [7:0] wr_data = '0;

    spi_reg_slave dut (
        .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .spioe(spioe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en)
            bank[pre_a] <= pre_d;
        else if (reg_wr)
            bank[reg_addr] <= reg_wdata;
        if (reg_rd)
            reg_rdata <= bank[reg_addr];
    end

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_cnt++;
            wr_addr = reg_addr;
            wr_data = reg_wdata;
        end
        if (reg_rd) begin
            rd_cnt++;
            rd_addr = reg_addr;
        end
        if (spioe && !(cur_rd && n_rise >= 8))
            oe_bad++;
        if (miso && !spioe)
            miso_bad++;
    end

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Master samples miso two clk after its rising edge to absorb the slave's synchroniser delay
    task automatic spi_frame(input logic [15:0] tx, input int half, input int nr,
                             input logic drop_last, input int rst_at, output logic [7:0] rx);
        rx = '0;
        n_rise = 0;
        ss = 1'b1;
        wait_clk(half + 2);
        for (int i = 0; i < nr; i++) begin
            sclk = 1'b0;
            mosi = tx[15-i];
            wait_clk(half);
            sclk = 1'b1;
            n_rise++;
            if (drop_last && i == 15)
                ss = 1'b0;
            wait_clk(2);
            if (i >= 8) begin
                rx = {rx[6:0], miso};
                if (cur_rd && nr == 16 && rst_at < 0 && !spioe)
                    oe_miss++;
            end
            wait_clk(half - 2);
            if (i == rst_at) begin
                reset = 1'b1;
                wait_clk(1);
                check("rst_outs", {miso, spioe, reg_wdata, reg_wr, reg_rd, frame_err, reg_addr}, 0);
                reset = 1'b0;
            end
        end
        ss = 1'b0;
        wait_clk(half + 6);
        n_rise = 0;
    endtask

    task automatic do_frame(input logic rd, input logic [6:0] a, input logic [7:0] d,
                            input int half, input int nr, input logic drop);
        logic [7:0] rx;
        int w0, r0;
        w0 = wr_cnt;
        r0 = rd_cnt;
        cur_rd = rd;
        spi_frame({rd, a, d}, half, nr, drop, -1, rx);
        cur_rd = 1'b0;
        if (nr < 16) begin
            err_exp = 1'b1;
            check("abort_nowr", wr_cnt - w0, 0);
        end else if (rd) begin
            check("rd_cnt", rd_cnt - r0, 1);
            check("rd_addr", rd_addr, a);
            check("rd_data", rx, model[a]);
            check("rd_nowr", wr_cnt - w0, 0);
        end else begin
            check("wr_cnt", wr_cnt - w0, 1);
            check("wr_addr", wr_addr, a);
            check("wr_data", wr_data, d);
            check("wr_nord", rd_cnt - r0, 0);
            model[a] = d;
        end
        check("frame_err", frame_err, err_exp);
    endtask

    initial begin
        logic [7:0] rx;
        int w0, r0;
        reset = 1'b1;
        sclk = 1'b1;
        ss = 1'b0;
        mosi = 1'b0;
        for (int i = 0; i < 128; i++) begin
            pre_d = (i == 0) ? 8'hC3 : 8'($urandom);
            pre_a = 7'(i);
            pre_en = 1'b1;
            model[i] = pre_d;
            wait_clk(1);
        end
        pre_en = 1'b0;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(1);
        check("rst_miso", miso, 0);
        check("rst_spioe", spioe, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_wdata", reg_wdata, 0);
        check("rst_wr", reg_wr, 0);
        check("rst_rd", reg_rd, 0);
        check("rst_err", frame_err, 0);

        do_frame(1'b0, 7'h55, 8'hAA, 8, 16, 1'b0);
        do_frame(1'b1, 7'h00, 8'h00, 8, 16, 1'b0);
        do_frame(1'b0, 7'h00, 8'h5A, 8, 16, 1'b0);
        do_frame(1'b1, 7'h00, 8'h00, 2, 16, 1'b0);
        do_frame(1'b0, 7'h12, 8'h99, 4, 11, 1'b0);
        do_frame(1'b0, 7'h12, 8'h34, 4, 16, 1'b0);

        w0 = wr_cnt;
        r0 = rd_cnt;
        for (int i = 0; i < 16; i++) begin
            sclk = 1'b0;
            mosi = 1'($urandom);
            wait_clk(2);
            sclk = 1'b1;
            wait_clk(2);
        end
        wait_clk(6);
        check("desel_wr", wr_cnt - w0, 0);
        check("desel_rd", rd_cnt - r0, 0);
        do_frame(1'b0, 7'h05, 8'h77, 4, 16, 1'b0);

        w0 = wr_cnt;
        r0 = rd_cnt;
        cur_rd = 1'b1;
        spi_frame({1'b1, 7'h21, 8'h00}, 4, 16, 1'b0, 10, rx);
        cur_rd = 1'b0;
        err_exp = 1'b0;
        check("rstmid_wr", wr_cnt - w0, 0);
        check("rstmid_rd", rd_cnt - r0, 1);
        check("rstmid_err", frame_err, 0);
        do_frame(1'b1, 7'h12, 8'h00, 4, 16, 1'b0);

        do_frame(1'b0, 7'h3C, 8'h96, 3, 16, 1'b1);
        do_frame(1'b1, 7'h3C, 8'h00, 3, 16, 1'b0);

        for (int k = 0; k < 30; k++) begin
            logic rd;
            int nr;
            rd = 1'($urandom);
            nr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 16;
            do_frame(rd, 7'($urandom), 8'($urandom), int'($urandom_range(2, 6)), nr,
                     !rd && nr == 16 && $urandom_range(0, 3) == 0);
        end

        check("oe_bad", oe_bad, 0);
        check("oe_miss", oe_miss, 0);
        check("miso_bad", miso_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

SPI slave front end for the motor controller. It sits between the external SPI pins (`sclk`, `ss`, `mosi`, `miso`) and the internal control-register bank. It oversamples the SPI lines in the `clk` domain, decodes 16-bit frames into register read and write cycles, and serialises read data back on `miso`.

## Interface
- `ADDR_W`, default 7: register address width; the first byte is read flag plus address.
- `SYNC_STAGES`, default 2: synchroniser depth on `sclk`, `ss` and `mosi`; minimum 2.
- `clk  in  1`: system clock; all logic is on its rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `sclk  in  1`: SPI clock, asynchronous. Idles high. The master shifts on falling edges; this block samples on rising edges.
- `ss  in  1`: slave select, active high, asynchronous.
- `mosi  in  1`: serial data in, MSB first.
- `miso  out  1`: serial data out, MSB first.
- `spioe  out  1`: `miso` output enable; high only during the data byte of a read frame.
- `reg_addr  out  ADDR_W`: register address, held from the end of the address byte to the end of the frame.
- `reg_wdata  out  8`: write data, valid while `reg_wr` is high.
- `reg_wr  out  1`: one-cycle write strobe.
- `reg_rd  out  1`: one-cycle read strobe.
- `reg_rdata  in  8`: read data. The bank must present it on the `clk` edge after `reg_rd`.
- `frame_err  out  1`: sticky flag for an aborted frame. Cleared only by `reset`.

## Operation
- Synchronisation:
  - `sclk`, `ss` and `mosi` each pass through `SYNC_STAGES` flops, so all three see identical delay.
  - One extra `sclk` flop provides edge detection. `rise` means the previous sample was 0 and the current sample is 1.
- Frame format: exactly 16 bits while `ss` is high.
  - Byte 0: bit 7 = R/nW, bits 6:0 = address.
  - Byte 1: write data for a write frame; don't-care for a read frame.
- State machine and bit counter (`bitcnt`, 4 bits):
  - IDLE: waits for synchronised `ss` = 1. Then `bitcnt` ← 0 and the block goes to ADDR.
  - ADDR: on each `rise`, shift in `mosi`. On the 8th `rise`:
    - latch `reg_addr` and the R/nW bit;
    - for a read, pulse `reg_rd` in the same cycle, load `reg_rdata` into the output shifter on the next cycle, and raise `spioe`;
    - go to DATA.
  - DATA, write frame: shift in `mosi` on each `rise`. On the 16th `rise`, `reg_wdata` ← the shifted byte, pulse `reg_wr` for one cycle, and go to DONE.
  - DATA, read frame: `miso` = shifter MSB. The shifter moves left on each `rise` after the load, so a new bit is presented just after each master sample. On the 16th `rise` go to DONE.
  - DONE: ignores further edges. `spioe` = 0. Returns to IDLE when `ss` = 0.
- Abort: if `ss` drops in ADDR or DATA before the 16th `rise`:
  - go to IDLE, set `frame_err`;
  - no `reg_wr` is issued; `spioe` → 0 on the same cycle.
- `sclk` activity while `ss` = 0 is ignored entirely; counters stay at 0.
- `miso` = 0 whenever `spioe` = 0.

## Timing
- Reset values: `miso` = 0, `spioe` = 0, `reg_addr` = 0, `reg_wdata` = 0, `reg_wr` = 0, `reg_rd` = 0, `frame_err` = 0, state = IDLE, `bitcnt` = 0.
- A reset mid-frame discards the frame. The block stays in IDLE until `ss` is seen low and then high again.
- Requirement on the master: each `sclk` high and low phase lasts at least 2 `clk` periods, and `ss` is asserted at least 2 `clk` periods before the first falling `sclk` edge.
- Edge detection latency: `SYNC_STAGES` + 1 `clk` cycles from the pin edge.
- Read path:
  - `reg_rd` fires on the cycle the 8th `rise` is detected.
  - The MSB of `reg_rdata` appears on `miso` 2 `clk` cycles later.
  - This is well before the 9th pin rising edge, which comes at least 4 `clk` after the 8th.
- Write path: `reg_wr` fires on the cycle the 16th `rise` is detected. `reg_addr` and `reg_wdata` are stable during it.
- Simultaneous events: if `ss` falls in the same cycle as the 16th `rise`, the frame completes. The write or read is honoured, `frame_err` is not set, and the block goes to IDLE.

## Test plan
- Write frame: `ss` = 1, send 0x55 then 0xAA with 8-`clk` `sclk` half-periods. Required: exactly one `reg_wr` with `reg_addr` = 0x55 and `reg_wdata` = 0xAA; `spioe` stays 0; `frame_err` = 0.
- Read frame: send 0x80 then 0x00, with the bank returning 0xC3 for address 0. Required: `reg_rd` once with `reg_addr` = 0x00; the master shifter captures 0xC3; `spioe` is high only during byte 1; no `reg_wr`.
- Minimum-speed `sclk`: repeat the read with 2-`clk` half-periods and data 0x5A. Required: 0x5A is captured without bit slip.
- Abort: drop `ss` after 11 rising edges of a write to 0x12. Required: no `reg_wr`, `frame_err` = 1. A following complete write to 0x12 with data 0x34 succeeds.
- Deselected clocks: 16 `sclk` pulses with `ss` = 0, then a valid write 0x05/0x77. Required: a single `reg_wr` for address 0x05 with data 0x77.
- Reset mid-read: assert `reset` during byte 1. Required: all outputs go to their reset values on the next `clk`. The next complete frame after an `ss` low/high cycle decodes correctly.
